// File: rtl/mest_pro_out_queue.sv
// rtl/mest_pro_out_queue.sv - display output queue: FIFO plus hold-time pacer for o_display
// Optional: MEST_OUT_QUEUE_BYPASS_EN lets a push into an idle, empty queue go straight to o_display.
module mest_pro_out_queue #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         i_reset_n,
    input  logic                         i_wr_en,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic                         i_flush,
    output logic [DATA_WIDTH-1:0]        o_display,
    output logic                         o_display_strobe,
    output logic                         o_busy,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_overflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [HOLD_W-1:0]     hold_cnt, hold_next;
    logic                  pop, bypass, push, load;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        pop        = 1'b0;
        bypass     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SHOW;
                    hold_next  = HOLD_LOAD;
                end
`ifdef MEST_OUT_QUEUE_BYPASS_EN
                else if (i_wr_en) begin
                    bypass     = 1'b1;
                    state_next = SHOW;
                    hold_next  = HOLD_LOAD;
                end
`endif
            end
            SHOW: begin
                if (hold_cnt != '0) begin
                    hold_next = hold_cnt - 1'b1;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    hold_next = HOLD_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over everything the pacer wanted to do this cycle
        if (i_flush) begin
            state_next = IDLE;
            hold_next  = '0;
            pop        = 1'b0;
            bypass     = 1'b0;
        end
    end

    // A full queue still accepts a push when the pacer frees a slot in the same cycle
    assign push = i_wr_en && !i_flush && !bypass && ((count != FULL_COUNT) || pop);
    assign load = pop || bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            o_display        <= '0;
            o_display_strobe <= 1'b0;
            o_overflow       <= 1'b0;
        end else if (i_flush) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            o_display        <= '0;
            o_display_strobe <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_display <= mem[rd_ptr];
            end else if (bypass) begin
                o_display <= i_wr_data;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            o_display_strobe <= load;
            if (i_wr_en && !push && !bypass) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_busy  = (state == SHOW);
    assign o_count = count;
    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);

endmodule

// File: tb/tb_mest_pro_out_queue.sv
// tb/tb_mest_pro_out_queue.sv - directed and randomized checks of mest_pro_out_queue against a queue model
module tb_mest_pro_out_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_wr_en;
    logic [DW-1:0] i_wr_data;
    logic          i_flush;
    logic [DW-1:0] o_display;
    logic          o_display_strobe;
    logic          o_busy;
    logic [2:0]    o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;

    mest_pro_out_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk              (clk),
        .i_reset_n        (i_reset_n),
        .i_wr_en          (i_wr_en),
        .i_wr_data        (i_wr_data),
        .i_flush          (i_flush),
        .o_display        (o_display),
        .o_display_strobe (o_display_strobe),
        .o_busy           (o_busy),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_overflow       (o_overflow)
    );

    always #5 clk = ~clk;

    // Model: a queue of pending values, the shown value, and the edge index at which the pacer may move on
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_disp;
    logic          m_strobe;
    logic          m_busy;
    logic          m_ovf;
    int            m_ready_at;
    int            edge_n;
    logic [DW-1:0] seen[$];

    task automatic model_reset();
        mq.delete();
        m_disp   = '0;
        m_strobe = 1'b0;
        m_busy   = 1'b0;
        m_ovf    = 1'b0;
        m_ready_at = 0;
    endtask

    task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic fl);
        logic do_pop;
        logic byp;
        int   n;
        edge_n++;
        if (fl) begin
            model_reset();
            return;
        end
        n      = mq.size();
        do_pop = (n > 0) && (!m_busy || edge_n >= m_ready_at);
        byp    = 1'b0;
`ifdef MEST_OUT_QUEUE_BYPASS_EN
        byp    = wr && !m_busy && (n == 0);
`endif
        m_strobe = do_pop || byp;
        if (do_pop)
            m_disp = mq.pop_front();
        else if (byp)
            m_disp = d;
        else if (m_busy && edge_n >= m_ready_at)
            m_busy = 1'b0;
        if (do_pop || byp) begin
            m_busy     = 1'b1;
            m_ready_at = edge_n + HOLD;
        end
        if (wr && !byp) begin
            if (n < DEPTH || do_pop)
                mq.push_back(d);
            else
                m_ovf = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("display", 32'(o_display), 32'(m_disp));
        check("strobe",  32'(o_display_strobe), 32'(m_strobe));
        check("busy",    32'(o_busy), 32'(m_busy));
        check("count",   32'(o_count), 32'(mq.size()));
        check("full",    32'(o_full), 32'(mq.size() == DEPTH));
        check("empty",   32'(o_empty), 32'(mq.size() == 0));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic wr, input logic [DW-1:0] d, input logic fl);
        i_wr_en   = wr;
        i_wr_data = d;
        i_flush   = fl;
        @(posedge clk);
        model_edge(wr, d, fl);
        #1;
        check_all();
        if (o_display_strobe) seen.push_back(o_display);
        i_wr_en = 1'b0;
        i_flush = 1'b0;
    endtask

    initial begin
        int density;
        logic [DW-1:0] exp_vals[$];
        int strobe_at[$];
        i_reset_n = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_flush   = 1'b0;
        edge_n    = 0;
        model_reset();
        #2;
        check("reset_display", 32'(o_display), 32'h0);
        check("reset_empty", 32'(o_empty), 32'h1);
        check("reset_busy", 32'(o_busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 i_reset_n = 1'b1;

        // Single value through an idle queue
        step(1'b1, 8'hA5, 1'b0);
`ifndef MEST_OUT_QUEUE_BYPASS_EN
        check("single_cnt1", 32'(o_count), 32'd1);
        check("single_nostrobe", 32'(o_display_strobe), 32'd0);
        step(1'b0, 8'h00, 1'b0);
`endif
        check("single_disp", 32'(o_display), 32'hA5);
        check("single_strobe", 32'(o_display_strobe), 32'd1);
        repeat (HOLD - 1) begin
            step(1'b0, 8'h00, 1'b0);
            check("single_hold_busy", 32'(o_busy), 32'd1);
        end
        step(1'b0, 8'h00, 1'b0);
        check("single_idle", 32'(o_busy), 32'd0);
        check("single_keep", 32'(o_display), 32'hA5);

        // Burst of three: strobes must be exactly HOLD cycles apart
        step(1'b1, 8'h01, 1'b0);
        if (o_display_strobe) strobe_at.push_back(edge_n);
        step(1'b1, 8'h02, 1'b0);
        if (o_display_strobe) strobe_at.push_back(edge_n);
        step(1'b1, 8'h03, 1'b0);
        if (o_display_strobe) strobe_at.push_back(edge_n);
        seen.delete();
        repeat (16) begin
            step(1'b0, 8'h00, 1'b0);
            if (o_display_strobe) strobe_at.push_back(edge_n);
        end
        check("burst_nstrobes", 32'(strobe_at.size()), 32'd3);
        if (strobe_at.size() == 3) begin
            check("burst_gap1", 32'(strobe_at[1] - strobe_at[0]), 32'(HOLD));
            check("burst_gap2", 32'(strobe_at[2] - strobe_at[1]), 32'(HOLD));
        end
        check("burst_last", 32'(o_display), 32'h03);
        check("burst_empty", 32'(o_empty), 32'd1);

        // Full with same-cycle pop, then overflow on a full queue
        step(1'b0, 8'h00, 1'b1);
        seen.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
`ifndef MEST_OUT_QUEUE_BYPASS_EN
        check("fullpop_count", 32'(o_count), 32'd4);
        check("fullpop_ovf", 32'(o_overflow), 32'd0);
`endif
        step(1'b1, 8'h17, 1'b0);
        step(1'b1, 8'h18, 1'b0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_full", 32'(o_full), 32'd1);
        repeat (30) step(1'b0, 8'h00, 1'b0);
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        exp_vals = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        check("ovf_nshown", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            check("ovf_order", 32'(seen[i]), 32'(exp_vals[i]));

        // Flush with a concurrent push: nothing survives
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_disp", 32'(o_display), 32'd0);
        check("flush_busy", 32'(o_busy), 32'd0);
        check("flush_ovf", 32'(o_overflow), 32'd0);
        repeat (10) begin
            step(1'b0, 8'h00, 1'b0);
            check("flush_quiet", 32'(o_display_strobe), 32'd0);
        end

        // Asynchronous reset in the middle of a hold
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
        #2 i_reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_display", 32'(o_display), 32'h0);
        check("rst_count", 32'(o_count), 32'h0);
        check("rst_empty", 32'(o_empty), 32'h1);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_ovf", 32'(o_overflow), 32'h0);
        @(posedge clk);
        #1 i_reset_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // Randomized traffic at several push densities
        for (int phase = 0; phase < 5; phase++) begin
            case (phase)
                0: density = 20;
                1: density = 50;
                2: density = 90;
                3: density = 100;
                default: density = 35;
            endcase
            repeat (400) begin
                step($urandom_range(0, 99) < density, 8'($urandom), $urandom_range(0, 149) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
